fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Byte-serial instruction fetch stage. Sits directly downstream of the program counter.
- Reads the current PC address, fetches the opcode byte plus 0–3 operand bytes over an 8-bit req/ack memory port, and pulses the PC to advance one byte per accepted transfer.
- Presents the assembled instruction to the decoder with a valid/ready handshake.
- Flushed by the ECU whenever the PC is reloaded (branch or jump).

Parameters:
- AW, 16, address width (PC and memory address).
- DW, 8, memory data width; fixed at 8, other values unsupported.
- ROM_BASE, 16'h8000, lowest legal fetch address; also the PC reset vector.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc_addr  in  AW  current PC byte address
- pc_adv  out  1  one-cycle pulse: PC increments by 1 this edge
- flush  in  1  PC reloaded this cycle; abort the in-flight instruction
- mem_req  out  1  memory read request, held until mem_ack
- mem_addr  out  AW  read address; equals pc_addr while mem_req=1
- mem_ack  in  1  read data valid this cycle
- mem_data  in  DW  read data
- ir_valid  out  1  instruction available
- ir_ready  in  1  decoder accepts the instruction
- ir_op  out  8  opcode byte
- ir_imm  out  24  operand bytes; byte1 in [7:0], byte2 in [15:8], byte3 in [23:16]; unused bytes are 0
- ir_len  out  2  number of operand bytes (0–3)
- ir_pc  out  AW  address of the opcode byte
- fault  out  1  fetch fault (see Optional Feature); 0 when the feature is absent

Behaviour:
- States: IDLE, FETCH, HOLD, FAULT.
- Reset (any state, any cycle): state=IDLE, byte count cnt=0, ir_valid=0, ir_op/ir_imm/ir_len/ir_pc=0, mem_req=0, fault=0.
- IDLE -> FETCH unconditionally on the next cycle.
- FETCH:
  - mem_req=1; mem_addr=pc_addr (combinational).
  - Accept: mem_req & mem_ack & ~flush.
  - pc_adv = mem_req & mem_ack & ~flush (combinational), so the PC holds the next byte address on the following cycle. Back-to-back requests need no gap.
  - Accept with cnt=0: ir_op<=mem_data; ir_pc<=pc_addr; ir_imm<=0; need<=mem_data[7:6]; ir_len<=mem_data[7:6].
  - Accept with cnt=k (k>0): ir_imm byte k-1 <= mem_data.
  - After an accept: if cnt==need (need taken from mem_data when cnt=0), go to HOLD with cnt<=0; otherwise cnt<=cnt+1.
  - Latency: instruction of n bytes with zero-wait memory: ir_valid rises n+1 cycles after FETCH entry (n ack cycles, then register).
- HOLD:
  - ir_valid=1; outputs stable; mem_req=0.
  - ir_valid & ir_ready -> FETCH next cycle, ir_valid<=0.
  - No prefetch while holding.
- flush, highest priority after rst, any state except FAULT:
  - Go to FETCH with cnt=0 and ir_valid<=0.
  - Data on a coincident ack is discarded; pc_adv is suppressed.
  - mem_req drops for exactly one cycle; memory treats a dropped req as cancel.
  - flush together with ir_valid & ir_ready: the handshake completes (instruction consumed), then flush semantics apply.
- mem_addr wraps modulo 2^AW. Without the optional feature, 16'hFFFF -> 16'h0000 is fetched silently.
- ir_len bit encoding (opcode[7:6]) is fixed: 00=1 byte, 01=2, 10=3, 11=4.

Optional Feature:
- Macro: FETCH_RANGE_CHECK_EN.
- Defined: on the cnt=0 accept, if pc_addr < ROM_BASE or pc_addr + mem_data[7:6] > 16'hFFFF:
  - Go to FAULT; fault<=1 (sticky); ir_valid stays 0; pc_adv is still pulsed for that byte.
  - FAULT: mem_req=0; ignores flush; exits only on rst.
- Undefined: no FAULT state; fault tied 0; wrap as above.

Decomposition:
- Package fetch_pkg:
  - state enum (IDLE, FETCH, HOLD, FAULT);
  - ROM_BASE_DEFAULT=16'h8000;
  - MAX_EXTRA=3;
  - LEN_MSB=7, LEN_LSB=6;
  - function op_len(opcode) returning 2 bits.
- No sub-module; single always_ff FSM plus combinational req/adv logic.

Test Plan:
- Reset, pc_addr=16'h8000, memory returns 8'h05 with zero-wait ack -> one pc_adv pulse; ir_valid, ir_op=8'h05, ir_len=0, ir_imm=0, ir_pc=16'h8000; ready=1 -> FETCH next cycle.
- Bytes 8'hC1,8'h11,8'h22,8'h33 from 16'h8010 -> four pc_adv pulses; ir_len=3, ir_imm=24'h332211, ir_pc=16'h8010.
- 2-byte op 8'h4A, ir_ready held 0 for 5 cycles -> outputs stable, mem_req=0, no pc_adv; release -> next fetch starts.
- Flush coincident with ack of operand byte 2 of a 3-byte op -> no pc_adv that cycle, ir_valid stays 0, cnt restarts at 0 from the new pc_addr 16'h9000.
- Memory ack delayed 3 cycles -> mem_req and mem_addr held constant for 4 cycles, single pc_adv pulse.
- FETCH_RANGE_CHECK_EN: opcode 8'hC0 at 16'hFFFE -> fault=1, FAULT held through flush; rst clears it. Without the macro: fetch wraps to 16'h0000, fault=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the byte-serial fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [15:0] ROM_BASE_DEFAULT = 16'h8000;
  localparam int          MAX_EXTRA        = 3;
  localparam int          CNT_W            = $clog2(MAX_EXTRA + 1);
  localparam int          IMM_W            = 8 * MAX_EXTRA;
  localparam int          LEN_MSB          = 7;
  localparam int          LEN_LSB          = 6;

  // Number of operand bytes that follow an opcode.
  function automatic logic [1:0] op_len(input logic [7:0] opcode);
    return opcode[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read port and decoder handshake of the fetch stage.
interface fetch_unit_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic          ir_valid;
  logic          ir_ready;
  logic [7:0]    ir_op;
  logic [23:0]   ir_imm;
  logic [1:0]    ir_len;
  logic [AW-1:0] ir_pc;

  modport master (
    output mem_req, mem_addr, ir_valid, ir_op, ir_imm, ir_len, ir_pc,
    input  mem_ack, mem_data, ir_ready
  );

  modport slave (
    input  mem_req, mem_addr, ir_valid, ir_op, ir_imm, ir_len, ir_pc,
    output mem_ack, mem_data, ir_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: assembles opcode plus 0-3 operand bytes for the decoder.
// Optional FETCH_RANGE_CHECK_EN traps fetches outside [ROM_BASE, top of address space].
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            DW       = 8,
  parameter logic [AW-1:0] ROM_BASE = AW'(ROM_BASE_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_addr,
  output logic          pc_adv,
  input  logic          flush,
  fetch_unit_if.master  bus,
  output logic          fault
);

`ifdef FETCH_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       need_r, need_s;
  logic             req_r, req_s;
  logic             valid_r, valid_s;
  logic [7:0]       op_r, op_s;
  logic [IMM_W-1:0] imm_r, imm_s;
  logic [1:0]       len_r, len_s;
  logic [AW-1:0]    irpc_r, irpc_s;
  logic             fault_r, fault_s;

  logic [DW-1:0]    byte_s;
  logic             accept_s;
  logic [1:0]       need_cmp_s;
  logic [AW:0]      wide_sum_s;
  logic             range_err_s;

  assign byte_s      = bus.mem_data;
  assign accept_s    = req_r & bus.mem_ack & ~flush;
  assign need_cmp_s  = (cnt_r == 2'd0) ? op_len(byte_s) : need_r;
  // Carry out of the sum means the last operand byte would wrap past the top address.
  assign wide_sum_s  = {1'b0, pc_addr} + {{(AW-1){1'b0}}, op_len(byte_s)};
  assign range_err_s = (pc_addr < ROM_BASE) | wide_sum_s[AW];

  assign pc_adv       = accept_s;
  assign bus.mem_req  = req_r;
  assign bus.mem_addr = pc_addr;
  assign bus.ir_valid = valid_r;
  assign bus.ir_op    = op_r;
  assign bus.ir_imm   = imm_r;
  assign bus.ir_len   = len_r;
  assign bus.ir_pc    = irpc_r;
  assign fault        = fault_r;

  // Next-state and next-datapath logic for the fetch FSM
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    need_s  = need_r;
    req_s   = req_r;
    valid_s = valid_r;
    op_s    = op_r;
    imm_s   = imm_r;
    len_s   = len_r;
    irpc_s  = irpc_r;
    fault_s = fault_r;
    case (state_r)
      IDLE: begin
        state_s = FETCH;
        req_s   = 1'b1;
      end
      FETCH: begin
        if (accept_s) begin
          if (cnt_r == 2'd0) begin
            op_s   = byte_s;
            irpc_s = pc_addr;
            imm_s  = 24'd0;
            need_s = op_len(byte_s);
            len_s  = op_len(byte_s);
          end else begin
            case (cnt_r)
              2'd1:    imm_s[7:0]   = byte_s;
              2'd2:    imm_s[15:8]  = byte_s;
              2'd3:    imm_s[23:16] = byte_s;
              default: imm_s        = imm_r;
            endcase
          end
          if (RANGE_CHECK && (cnt_r == 2'd0) && range_err_s) begin
            state_s = FAULT;
            fault_s = 1'b1;
            req_s   = 1'b0;
            cnt_s   = 2'd0;
          end else if (cnt_r == need_cmp_s) begin
            state_s = HOLD;
            cnt_s   = 2'd0;
            req_s   = 1'b0;
            valid_s = 1'b1;
          end else begin
            cnt_s = cnt_r + 2'd1;
          end
        end else begin
          // Re-arm the request after the one-cycle drop that follows a flush.
          req_s = 1'b1;
        end
      end
      HOLD: begin
        if (bus.ir_ready) begin
          state_s = FETCH;
          valid_s = 1'b0;
          req_s   = 1'b1;
        end else begin
          valid_s = 1'b1;
        end
      end
      FAULT: begin
        req_s   = 1'b0;
        valid_s = 1'b0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
        req_s   = 1'b0;
        valid_s = 1'b0;
      end
    endcase
    // A PC reload aborts everything except a trapped fetch.
    if (flush && (state_r != FAULT)) begin
      state_s = FETCH;
      cnt_s   = 2'd0;
      valid_s = 1'b0;
      req_s   = 1'b0;
    end else begin
      fault_s = fault_s | 1'b0;
    end
  end

  // State and datapath register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      need_r  <= 2'd0;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      op_r    <= 8'd0;
      imm_r   <= 24'd0;
      len_r   <= 2'd0;
      irpc_r  <= {AW{1'b0}};
      fault_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      need_r  <= need_s;
      req_r   <= req_s;
      valid_r <= valid_s;
      op_r    <= op_s;
      imm_r   <= imm_s;
      len_r   <= len_s;
      irpc_r  <= irpc_s;
      fault_r <= fault_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bench-side PC and memory models, scoreboard of expected instructions.
module tb_fetch_unit;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] imm;
    logic [1:0]  len;
    logic [15:0] pc;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_addr;
  logic        pc_adv;
  logic        flush;
  logic        fault;

  fetch_unit_if #(.AW(16), .DW(8)) bus ();

  instr_t      sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          adv_cnt = 0;
  int          ack_delay = 0;
  int          wait_ctr = 0;
  int          cyc;
  logic        last_adv = 1'b0;
  logic        ack_en;
  logic [15:0] flush_target;
  logic [49:0] snap;
  logic [7:0]  mem [0:65535];

  assign bus.mem_data = mem[bus.mem_addr];
  assign bus.mem_ack  = bus.mem_req & ack_en & (wait_ctr >= ack_delay);

  always #5 clk = ~clk;

  fetch_unit #(.AW(16), .DW(8), .ROM_BASE(16'h8000)) dut (
    .clk     (clk),
    .rst     (rst),
    .pc_addr (pc_addr),
    .pc_adv  (pc_adv),
    .flush   (flush),
    .bus     (bus),
    .fault   (fault)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just before the edge, update the PC model and wait counter after it.
  task automatic cycle();
    logic req, ack;
    #3;
    last_adv = pc_adv;
    req      = bus.mem_req;
    ack      = bus.mem_ack;
    @(posedge clk);
    #1;
    if (last_adv) adv_cnt++;
    if (flush) pc_addr = flush_target;
    else if (last_adv) pc_addr = pc_addr + 16'd1;
    wait_ctr = (req && !ack) ? wait_ctr + 1 : 0;
    flush    = 1'b0;
  endtask

  task automatic handshake();
    bus.ir_ready = 1'b1;
    cycle();
    bus.ir_ready = 1'b0;
  endtask

  task automatic jump(input logic [15:0] target);
    ack_en       = 1'b0;
    flush        = 1'b1;
    flush_target = target;
    cycle();
    ack_en       = 1'b1;
  endtask

  task automatic push(input logic [7:0] op, input logic [23:0] imm, input logic [1:0] len,
                      input logic [15:0] pc);
    instr_t e;
    e.op = op; e.imm = imm; e.len = len; e.pc = pc;
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.ir_valid && n < 40) begin
      cycle();
      n++;
    end
    check("valid_seen", bus.ir_valid, 1);
  endtask

  task automatic pop_check();
    instr_t e;
    check("sb_pending", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("ir_op", bus.ir_op, e.op);
      check("ir_imm", bus.ir_imm, e.imm);
      check("ir_len", bus.ir_len, e.len);
      check("ir_pc", bus.ir_pc, e.pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b1; flush = 1'b0; flush_target = 16'h0000; ack_en = 1'b1;
    bus.ir_ready = 1'b0; pc_addr = 16'h8000;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    check("rst_valid", bus.ir_valid, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_fields", {bus.ir_op, bus.ir_imm, bus.ir_len, bus.ir_pc}, 50'd0);
    check("rst_fault", fault, 0);

    // 1-byte opcode at the reset vector
    mem[16'h8000] = 8'h05;
    push(8'h05, 24'h000000, 2'd0, 16'h8000);
    rst = 1'b0;
    adv_cnt = 0;
    wait_valid(cyc);
    pop_check();
    check("t1_adv", adv_cnt, 1);
    ack_en = 1'b0;
    handshake();
    check("t1_refetch_req", bus.mem_req, 1);
    check("t1_refetch_addr", bus.mem_addr, 16'h8001);
    check("t1_valid_drop", bus.ir_valid, 0);

    // 4-byte opcode after a PC reload
    mem[16'h8010] = 8'hC1; mem[16'h8011] = 8'h11; mem[16'h8012] = 8'h22; mem[16'h8013] = 8'h33;
    jump(16'h8010);
    check("flush_req_drop", bus.mem_req, 0);
    push(8'hC1, 24'h332211, 2'd3, 16'h8010);
    adv_cnt = 0;
    cycle();
    check("flush_req_rearm", bus.mem_req, 1);
    wait_valid(cyc);
    pop_check();
    check("t2_adv", adv_cnt, 4);

    // 2-byte opcode, decoder stalls for 5 cycles
    mem[16'h8014] = 8'h4A; mem[16'h8015] = 8'h5B; mem[16'h8016] = 8'h00;
    push(8'h4A, 24'h00005B, 2'd1, 16'h8014);
    handshake();
    wait_valid(cyc);
    check("t3_latency", cyc, 3);
    pop_check();
    snap = {bus.ir_op, bus.ir_imm, bus.ir_len, bus.ir_pc};
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_stable", {bus.ir_op, bus.ir_imm, bus.ir_len, bus.ir_pc}, snap);
      check("hold_valid", bus.ir_valid, 1);
      check("hold_req", bus.mem_req, 0);
      check("hold_adv", last_adv, 0);
    end
    handshake();
    check("t3_release_req", bus.mem_req, 1);
    check("t3_release_addr", bus.mem_addr, 16'h8016);
    push(8'h00, 24'h000000, 2'd0, 16'h8016);
    wait_valid(cyc);
    pop_check();

    // Flush on the ack of the second operand byte of a 3-byte opcode
    mem[16'h8017] = 8'h85; mem[16'h8018] = 8'hAA; mem[16'h8019] = 8'hBB;
    mem[16'h9000] = 8'h03;
    handshake();
    cycle();
    cycle();
    flush = 1'b1;
    flush_target = 16'h9000;
    cycle();
    check("t4_adv_suppressed", last_adv, 0);
    check("t4_valid", bus.ir_valid, 0);
    check("t4_req_drop", bus.mem_req, 0);
    push(8'h03, 24'h000000, 2'd0, 16'h9000);
    adv_cnt = 0;
    wait_valid(cyc);
    pop_check();
    check("t4_adv", adv_cnt, 1);

    // Memory answers after 3 wait cycles
    mem[16'h9001] = 8'h07;
    ack_delay = 3;
    push(8'h07, 24'h000000, 2'd0, 16'h9001);
    handshake();
    adv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      check("t5_req_held", bus.mem_req, 1);
      check("t5_addr_held", bus.mem_addr, 16'h9001);
      cycle();
    end
    check("t5_adv", adv_cnt, 1);
    wait_valid(cyc);
    pop_check();
    ack_delay = 0;

    // 4-byte opcode at the top of the address space
    mem[16'hFFFE] = 8'hC0; mem[16'hFFFF] = 8'h01; mem[16'h0000] = 8'h02; mem[16'h0001] = 8'h03;
    ack_en = 1'b0;
    handshake();
    jump(16'hFFFE);
    adv_cnt = 0;
`ifdef FETCH_RANGE_CHECK_EN
    cycle();
    cycle();
    check("rc_adv", last_adv, 1);
    check("rc_fault", fault, 1);
    check("rc_valid", bus.ir_valid, 0);
    check("rc_req", bus.mem_req, 0);
    flush = 1'b1;
    flush_target = 16'h8000;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rc_fault_sticky", fault, 1);
      check("rc_req_idle", bus.mem_req, 0);
      check("rc_no_adv", last_adv, 0);
    end
    rst = 1'b1;
    cycle();
    check("rc_rst_fault", fault, 0);
    check("rc_rst_req", bus.mem_req, 0);
    rst = 1'b0;
`else
    push(8'hC0, 24'h030201, 2'd3, 16'hFFFE);
    wait_valid(cyc);
    pop_check();
    check("wrap_adv", adv_cnt, 4);
    check("wrap_pc", pc_addr, 16'h0002);
    check("wrap_fault", fault, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
